// File: rtl/eth_mdio_pkg.sv
// Shared MDIO (Clause 22) definitions: frame constants, field widths, and
// the responder state encoding.
package eth_mdio_pkg;

  localparam logic [1:0] C_MDIO_ST    = 2'b01;
  localparam logic [1:0] C_MDIO_OP_WR = 2'b01;
  localparam logic [1:0] C_MDIO_OP_RD = 2'b10;

  localparam int C_PHYAD_W = 5;
  localparam int C_REGAD_W = 5;
  localparam int C_DATA_W  = 16;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_ST    = 4'd1,
    S_OP    = 4'd2,
    S_PHYAD = 4'd3,
    S_REGAD = 4'd4,
    S_TA    = 4'd5,
    S_DATA  = 4'd6
  } mdio_state_e;

endpackage

// File: rtl/eth_mdio_sync.sv
// Two-flop synchronizers for MDC and MDIO, plus a one-clk MDC rising-edge strobe
// aligned with the synchronized MDIO sample.
module eth_mdio_sync (
  input  logic clk,
  input  logic rst,
  input  logic mdc,
  input  logic mdio,
  output logic mdc_rise,
  output logic mdio_s
);

  logic mdc_p0, mdc_p1, mdc_p2;
  logic mdio_p0, mdio_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      mdc_p0 <= 1'b0;
      mdc_p1 <= 1'b0;
      mdc_p2 <= 1'b0;
    end else begin
      mdc_p0 <= mdc;
      mdc_p1 <= mdc_p0;
      mdc_p2 <= mdc_p1;
    end
  end

  always_ff @(posedge clk) begin
    mdio_p0 <= mdio;
    mdio_p1 <= mdio_p0;
  end

  assign mdc_rise = mdc_p1 & ~mdc_p2;
  assign mdio_s   = mdio_p1;

endmodule

// File: rtl/eth_mdio_slave.sv
// MDIO Clause 22 responder: decodes frames addressed to usr_phy_addr onto a
// simple register port and drives turnaround/data back for reads.
module eth_mdio_slave
  import eth_mdio_pkg::*;
#(
  parameter int G_PRE_MIN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p_in_mdc,
  input  logic                 p_in_mdio,
  output logic                 p_out_mdio,
  output logic                 p_out_mdio_t,
  input  logic [C_PHYAD_W-1:0] usr_phy_addr,
  output logic                 usr_rd,
  output logic                 usr_wr,
  output logic [C_REGAD_W-1:0] usr_addr,
  output logic [C_DATA_W-1:0]  usr_wdata,
  input  logic [C_DATA_W-1:0]  usr_rdata,
  output logic                 usr_busy,
  output logic [7:0]           dbg_o
);

  logic mdc_rise;
  logic mdio_s;

  mdio_state_e         state_q, state_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [5:0]          pre_cnt_q, pre_cnt_d;
  logic                op_msb_q;
  logic                is_rd_q;
  logic                match_q;
  logic                rd_vld_p1;
  logic [C_DATA_W-1:0] sh_q;
  logic [4:0]          field5;

  logic op_first, op_done, last_phy, last_reg;
  logic rd_fire, wr_fire, drv_ta, drv_shift, drv_rel, sh_in;

  function automatic logic [5:0] sat_inc(input logic [5:0] c);
    if (c >= 6'(G_PRE_MIN)) return 6'(G_PRE_MIN);
    return c + 6'd1;
  endfunction

  eth_mdio_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .mdc      (p_in_mdc),
    .mdio     (p_in_mdio),
    .mdc_rise (mdc_rise),
    .mdio_s   (mdio_s)
  );

  assign field5 = {sh_q[3:0], mdio_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      pre_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pre_cnt_d = pre_cnt_q;
    if (mdc_rise) begin
      bit_cnt_d = bit_cnt_q + 5'd1;
      case (state_q)
        S_IDLE: begin
          bit_cnt_d = '0;
          if (mdio_s) begin
            pre_cnt_d = sat_inc(pre_cnt_q);
          end else begin
            pre_cnt_d = '0;
            if (pre_cnt_q >= 6'(G_PRE_MIN)) state_d = S_ST;
          end
        end
        S_ST: begin
          bit_cnt_d = '0;
          state_d   = (mdio_s == C_MDIO_ST[0]) ? S_OP : S_IDLE;
        end
        S_OP: begin
          if (bit_cnt_q[0]) begin
            bit_cnt_d = '0;
            if ({op_msb_q, mdio_s} == C_MDIO_OP_WR || {op_msb_q, mdio_s} == C_MDIO_OP_RD)
              state_d = S_PHYAD;
            else
              state_d = S_IDLE;
          end
        end
        S_PHYAD: begin
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = '0;
            state_d   = S_REGAD;
          end
        end
        S_REGAD: begin
          if (bit_cnt_q == 5'd4) begin
            bit_cnt_d = '0;
            state_d   = S_TA;
          end
        end
        S_TA: begin
          if (bit_cnt_q[0]) begin
            bit_cnt_d = '0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          if (bit_cnt_q == 5'd15) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end
        end
        default: begin
          bit_cnt_d = '0;
          state_d   = S_IDLE;
        end
      endcase
    end
  end

  // Strobe decode; a read-matched frame turns the shift register around
  // from capture to drive once REGAD has been taken.
  always_comb begin
    op_first  = mdc_rise && state_q == S_OP && !bit_cnt_q[0];
    op_done   = mdc_rise && state_q == S_OP && bit_cnt_q[0];
    last_phy  = mdc_rise && state_q == S_PHYAD && bit_cnt_q == 5'd4;
    last_reg  = mdc_rise && state_q == S_REGAD && bit_cnt_q == 5'd4;
    rd_fire   = last_reg && is_rd_q && match_q;
    wr_fire   = mdc_rise && state_q == S_DATA && bit_cnt_q == 5'd15 && !is_rd_q && match_q;
    drv_ta    = mdc_rise && state_q == S_TA && bit_cnt_q == 5'd0 && is_rd_q && match_q;
    drv_shift = mdc_rise && is_rd_q && match_q &&
                ((state_q == S_TA && bit_cnt_q == 5'd1) ||
                 (state_q == S_DATA && bit_cnt_q != 5'd15));
    drv_rel   = mdc_rise && state_q == S_DATA && bit_cnt_q == 5'd15;
    sh_in     = mdc_rise && !(is_rd_q && (state_q == S_TA || state_q == S_DATA));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      usr_rd       <= 1'b0;
      usr_wr       <= 1'b0;
      rd_vld_p1    <= 1'b0;
      usr_addr     <= '0;
      usr_wdata    <= '0;
      op_msb_q     <= 1'b0;
      is_rd_q      <= 1'b0;
      match_q      <= 1'b0;
      p_out_mdio_t <= 1'b1;
      p_out_mdio   <= 1'b1;
    end else begin
      usr_rd    <= rd_fire;
      usr_wr    <= wr_fire;
      rd_vld_p1 <= usr_rd;
      if (op_first) op_msb_q <= mdio_s;
      if (op_done)  is_rd_q  <= ({op_msb_q, mdio_s} == C_MDIO_OP_RD);
      if (last_phy) match_q  <= (field5 == usr_phy_addr);
      if (last_reg) usr_addr <= field5;
      if (wr_fire)  usr_wdata <= {sh_q[14:0], mdio_s};
      if (drv_ta) begin
        p_out_mdio_t <= 1'b0;
        p_out_mdio   <= 1'b0;
      end else if (drv_shift) begin
        p_out_mdio   <= sh_q[15];
      end else if (drv_rel) begin
        p_out_mdio_t <= 1'b1;
        p_out_mdio   <= 1'b1;
      end
    end
  end

  // p1: read data arrives one clk after usr_rd and is loaded for shifting out
  always_ff @(posedge clk) begin
    if (rd_vld_p1)      sh_q <= usr_rdata;
    else if (drv_shift) sh_q <= {sh_q[14:0], 1'b0};
    else if (sh_in)     sh_q <= {sh_q[14:0], mdio_s};
  end

  assign usr_busy = (state_q != S_IDLE);
  assign dbg_o    = {bit_cnt_q[3:0], state_q};

endmodule

// File: doc/eth_mdio_slave.md
# eth_mdio_slave

MDIO (IEEE 802.3 Clause 22) responder: the PHY-side end of the management link driven by `eth_mdio`. It oversamples MDC/MDIO in the system clock domain, decodes read and write frames addressed to its PHY address, and maps them onto a simple register port. On reads it drives turnaround and data back onto the shared MDIO line. It serves as an on-chip PHY register model and as the loopback partner in the `eth_mdio` testbench.

## Interface
- `G_PRE_MIN`, default 32: consecutive preamble 1s required before ST; legal range 1..32.
- `clk` in 1: system clock. All logic is in this single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `p_in_mdc` in 1: MDC from the master, asynchronous to `clk`.
- `p_in_mdio` in 1: MDIO line input, asynchronous.
- `p_out_mdio` out 1: MDIO drive value.
- `p_out_mdio_t` out 1: tristate control; 1 = released (high-Z), 0 = driving.
- `usr_phy_addr` in 5: own PHY address. Compared at the last PHYAD bit.
- `usr_rd` out 1: one-clk read request pulse.
- `usr_wr` out 1: one-clk write strobe.
- `usr_addr` out 5: register address; valid with `usr_rd` and `usr_wr`, held until the next frame.
- `usr_wdata` out 16: write data; valid with `usr_wr`.
- `usr_rdata` in 16: read data. Must be valid exactly 1 clk after `usr_rd`.
- `usr_busy` out 1: high from the ST first bit until the frame ends or aborts.
- `dbg_o` out 8: [3:0] state, [7:4] bit counter low nibble.

## Operation
- Synchronizers:
  - `p_in_mdc` and `p_in_mdio` each pass through 2 flops.
  - A third MDC flop detects the rising edge (`sync=1`, `prev=0`). This gives a 1-clk `mdc_rise`.
  - All sampling and all output updates occur only on `mdc_rise` cycles. MDIO is sampled through the same 2-flop delay as MDC.
- States:
  - IDLE: count consecutive 1s, saturating at `G_PRE_MIN`. On a 0:
    - if count ≥ `G_PRE_MIN`, go to ST;
    - otherwise clear the count.
  - ST: expects the second ST bit = 1.
    - If 1, go to OP.
    - If 0, go to IDLE with count 0.
  - OP: 2 bits.
    - 01 = write, 10 = read.
    - 00 or 11 goes to IDLE (frame ignored, count 0).
  - PHYAD: 5 bits, MSB first. On the 5th bit, latch the match flag `{phyad} == usr_phy_addr`.
  - REGAD: 5 bits, MSB first. On the 5th bit:
    - latch `usr_addr`;
    - if read and matched, pulse `usr_rd`.
  - TA: 2 bits. Master TA values are not checked.
  - DATA: 16 bits, then return to IDLE with count 0. A new preamble is mandatory.
- Write frame:
  - Shift in D15..D0.
  - On the D0 sample, if matched, pulse `usr_wr` with `usr_wdata` = the 16 captured bits.
- Read frame, matched (k = the `mdc_rise` that samples the last REGAD bit):
  - Edge k: bus stays released. `usr_rd` pulses; `usr_rdata` is captured into the shift register at k+1 clk.
  - Edge k+1: `p_out_mdio_t`=0, `p_out_mdio`=0 (TA second bit).
  - Edges k+2..k+17: drive D15..D0.
  - Edge k+18: release (`t`=1, `p_out_mdio`=1).
- Unmatched frames:
  - The full frame length is still counted.
  - No strobes are issued and the bus is never driven.
- Write frames never drive the bus.

## Timing
- Reset values:
  - `p_out_mdio_t`=1, `p_out_mdio`=1;
  - `usr_rd`=0, `usr_wr`=0;
  - `usr_addr`=0, `usr_wdata`=0;
  - `usr_busy`=0;
  - state IDLE, preamble count 0.
- `rst` mid-frame: the bus is released on the clk after `rst` is asserted. No strobe is issued, and any pending `usr_rd` is cancelled.
- MDC high and low phases must each be ≥ 3 clk. Shorter phases are unsupported.
- Pin-to-sample latency is 3 clk after the MDC rise. Output changes 1 clk after `mdc_rise`, i.e. 4 clk after the pin edge. This gives the master a full MDC period before it samples.
- `usr_rd` and `usr_wr` are never asserted in the same cycle, and are never asserted back-to-back within one frame.
- 1s on the bus after DATA count toward the next frame's preamble.

## Structure
- Package `eth_mdio_pkg`, shared with `eth_mdio`:
  - constants `C_MDIO_ST=2'b01`, `C_MDIO_OP_WR=2'b01`, `C_MDIO_OP_RD=2'b10`;
  - field widths (5/5/16);
  - state enum.
- Sub-module `eth_mdio_sync`: 2-flop synchronizer for MDC and MDIO plus the MDC rising-edge detect.

## Test plan
- Write, phy 0x06, reg 0x0B, data 0x8FFA, `usr_phy_addr`=0x06, stimulus from `eth_mdio` master (`G_DIV`=2) → one `usr_wr` pulse with `usr_addr`=0x0B, `usr_wdata`=0x8FFA; bus never driven.
- Read, phy 0x06, reg 0x02, `usr_rdata`=0x0141 → `usr_rd` pulse with `usr_addr`=0x02; TA second bit 0; master `usr_rxd`=0x0141; bus released after D0.
- Read to phy 0x07 while `usr_phy_addr`=0x06 → no `usr_rd`/`usr_wr`; `p_out_mdio_t` stays 1 for the whole frame.
- Preamble of 31 ones with `G_PRE_MIN`=32 → frame ignored; next frame with a full preamble decoded normally.
- `rst` asserted at data bit D8 of a read → `p_out_mdio_t`=1 next clk; the following write frame is decoded correctly.
- Back-to-back write then read, each with a 32-bit preamble, plus an OP=11 frame in between → the OP=11 frame is ignored; write and read behave as in the first two scenarios.
